// File: rtl/lfsr_prng_if.sv
// Output word stream of the LFSR generator: valid/ready handshake carrying one
// pseudo-random word per transfer.
interface lfsr_prng_if #(
    parameter int WIDTH = 64
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR word generator: STEPS_PER_WORD shifts per delivered word,
// seed reload with all-ones lock-up correction and an accepted-word counter.
module lfsr_prng #(
    parameter int               WIDTH          = 64,
    parameter logic [WIDTH-1:0] TAPS           = 64'hD800_0000_0000_0000,
    parameter int               STEPS_PER_WORD = 1,
    parameter logic [WIDTH-1:0] RESET_SEED     = '0,
    parameter int               CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_load_i,
    input  logic [WIDTH-1:0]   seed_i,
    input  logic               enable_i,
    output logic               lockup_fix_o,
    output logic [CNT_W-1:0]   word_count_o,
    lfsr_prng_if.master        out_if
);

    localparam int SC_W = (STEPS_PER_WORD > 1) ? $clog2(STEPS_PER_WORD) : 1;
    localparam logic [SC_W-1:0] LAST_STEP = SC_W'(STEPS_PER_WORD - 1);

    if (WIDTH < 3) begin : g_bad_width
        $error("lfsr_prng: WIDTH must be >= 3");
    end
    if (STEPS_PER_WORD < 1) begin : g_bad_steps
        $error("lfsr_prng: STEPS_PER_WORD must be >= 1");
    end
    if (RESET_SEED == {WIDTH{1'b1}}) begin : g_bad_seed
        $error("lfsr_prng: RESET_SEED must not be the all-ones lock-up state");
    end
    if (TAPS == '0) begin : g_bad_taps
        $error("lfsr_prng: TAPS must select at least one bit");
    end

    typedef enum logic [1:0] {IDLE, GEN, HOLD} fsm_t;

    fsm_t             fsm_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             lockup_fix_q;
    logic [SC_W-1:0]  step_cnt_q;
    logic [CNT_W-1:0] word_count_q;

    logic             fb_d;
    logic [WIDTH-1:0] lfsr_step_d;
    logic             seed_lock_d;
    logic [WIDTH-1:0] seed_fixed_d;
    logic             handshake_d;

    // XNOR feedback makes all-ones (not zero) the single lock-up state.
    assign fb_d         = ~^(lfsr_q & TAPS);
    assign lfsr_step_d  = {lfsr_q[WIDTH-2:0], fb_d};
    assign seed_lock_d  = &seed_i;
    assign seed_fixed_d = seed_lock_d ? {seed_i[WIDTH-1:1], 1'b0} : seed_i;
    assign handshake_d  = out_valid_q && out_if.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            lfsr_q       <= RESET_SEED;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            lockup_fix_q <= 1'b0;
            step_cnt_q   <= '0;
            word_count_q <= '0;
        end else begin
            lockup_fix_q <= 1'b0;
            // A handshake coinciding with seed_load still delivers its word.
            if (handshake_d) begin
                word_count_q <= word_count_q + CNT_W'(1);
            end
            if (seed_load_i) begin
                lfsr_q       <= seed_fixed_d;
                lockup_fix_q <= seed_lock_d;
                fsm_q        <= IDLE;
                step_cnt_q   <= '0;
                out_valid_q  <= 1'b0;
            end else begin
                case (fsm_q)
                    IDLE: begin
                        if (enable_i) begin
                            fsm_q      <= GEN;
                            step_cnt_q <= '0;
                        end
                    end
                    GEN: begin
                        if (enable_i) begin
                            lfsr_q <= lfsr_step_d;
                            if (step_cnt_q == LAST_STEP) begin
                                out_data_q  <= lfsr_step_d;
                                out_valid_q <= 1'b1;
                                step_cnt_q  <= '0;
                                fsm_q       <= HOLD;
                            end else begin
                                step_cnt_q <= step_cnt_q + SC_W'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (handshake_d) begin
                            out_valid_q <= 1'b0;
                            fsm_q       <= enable_i ? GEN : IDLE;
                        end
                    end
                    default: fsm_q <= IDLE;
                endcase
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign lockup_fix_o     = lockup_fix_q;
    assign word_count_o     = word_count_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: an 8-bit instance (4-bit counter, exercises wrap) and a
// 64-bit default-tap instance with 8 steps per word, both checked every cycle.
module tb_lfsr_prng;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // 8-bit instance
    logic       sl8, en8, fix8;
    logic [7:0] seed8;
    logic [3:0] cnt8;
    lfsr_prng_if #(.WIDTH(8)) bus8 ();

    lfsr_prng #(
        .WIDTH(8), .TAPS(8'hB8), .STEPS_PER_WORD(1), .RESET_SEED(8'h00), .CNT_W(4)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .seed_load_i(sl8), .seed_i(seed8),
        .enable_i(en8), .lockup_fix_o(fix8), .word_count_o(cnt8), .out_if(bus8)
    );

    // 64-bit instance
    logic        sl64, en64, fix64;
    logic [63:0] seed64;
    logic [31:0] cnt64;
    lfsr_prng_if #(.WIDTH(64)) bus64 ();

    lfsr_prng #(
        .STEPS_PER_WORD(8)
    ) u_dut64 (
        .clk(clk), .rst_n(rst_n), .seed_load_i(sl64), .seed_i(seed64),
        .enable_i(en64), .lockup_fix_o(fix64), .word_count_o(cnt64), .out_if(bus64)
    );

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] taps,
                                              input logic [63:0] mask);
        bit fb;
        fb = ($countones(s & taps) % 2) == 0;
        return ((s << 1) | {63'b0, fb}) & mask;
    endfunction

    function automatic logic [63:0] taps_of(input int k);
        return (k == 0) ? 64'hB8 : 64'hD800_0000_0000_0000;
    endfunction
    function automatic logic [63:0] wmask_of(input int k);
        return (k == 0) ? 64'hFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction
    function automatic logic [31:0] cmask_of(input int k);
        return (k == 0) ? 32'hF : 32'hFFFF_FFFF;
    endfunction
    function automatic int steps_of(input int k);
        return (k == 0) ? 1 : 8;
    endfunction

    logic [63:0] m_state [2];
    logic [63:0] m_data  [2];
    logic [31:0] m_cnt   [2];
    bit          m_valid [2];
    bit          m_active[2];
    bit          m_fix   [2];
    int          m_steps [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = '0; m_data[k] = '0; m_cnt[k] = '0;
            m_valid[k] = 0; m_active[k] = 0; m_fix[k] = 0; m_steps[k] = 0;
        end
    endtask

    // One clock of the generator: count steps while enabled, present a word after
    // steps_of(k) steps, hold it until accepted; seed loads override everything.
    task automatic model_cycle(input int k, input bit sl, input logic [63:0] sd,
                               input bit en, input bit rdy);
        bit hs;
        hs = m_valid[k] && rdy;
        m_fix[k] = 0;
        if (hs) m_cnt[k] = (m_cnt[k] + 32'd1) & cmask_of(k);
        if (sl) begin
            m_fix[k]    = (sd == wmask_of(k));
            m_state[k]  = m_fix[k] ? (sd & ~64'h1) : sd;
            m_active[k] = 0;
            m_steps[k]  = 0;
            m_valid[k]  = 0;
        end else if (m_valid[k]) begin
            if (hs) begin
                m_valid[k]  = 0;
                m_active[k] = en;
                m_steps[k]  = 0;
            end
        end else if (!m_active[k]) begin
            if (en) begin
                m_active[k] = 1;
                m_steps[k]  = 0;
            end
        end else if (en) begin
            m_state[k] = lfsr_step(m_state[k], taps_of(k), wmask_of(k));
            m_steps[k]++;
            if (m_steps[k] == steps_of(k)) begin
                m_data[k]  = m_state[k];
                m_valid[k] = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_cycle(0, sl8, {56'b0, seed8}, en8, bus8.out_ready);
            model_cycle(1, sl64, seed64, en64, bus64.out_ready);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("valid8", {63'b0, bus8.out_valid}, {63'b0, m_valid[0]});
        check("data8",  {56'b0, bus8.out_data}, m_data[0]);
        check("fix8",   {63'b0, fix8}, {63'b0, m_fix[0]});
        check("cnt8",   {60'b0, cnt8}, {32'b0, m_cnt[0]});
        check("valid64", {63'b0, bus64.out_valid}, {63'b0, m_valid[1]});
        check("data64",  bus64.out_data, m_data[1]);
        check("fix64",   {63'b0, fix64}, {63'b0, m_fix[1]});
        check("cnt64",   {32'b0, cnt64}, {32'b0, m_cnt[1]});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid8(output logic [7:0] w, output int c);
        int n;
        n = 0;
        while (!bus8.out_valid && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (!bus8.out_valid) begin
            fails++;
            $display("FAIL wait_valid8: out_valid still %b after %0d cycles, required 1", bus8.out_valid, n);
        end
        w = bus8.out_data;
        c = cyc_n;
    endtask

    logic [7:0]  w8, held8;
    logic [7:0]  exp_words [4];
    int          c_prev, c_now, n, first_zero, cnt_save32;
    bit          saw_ff;
    logic [63:0] s16, s8m;

    initial begin
        rst_n = 1'b1;
        sl8 = 0; en8 = 0; seed8 = '0; bus8.out_ready = 0;
        sl64 = 0; en64 = 0; seed64 = '0; bus64.out_ready = 0;
        exp_words[0] = 8'h03; exp_words[1] = 8'h07; exp_words[2] = 8'h0F; exp_words[3] = 8'h1E;

        // Pin the model's period against hand-known values.
        s8m = 64'h0; n = 0;
        do begin s8m = lfsr_step(s8m, 64'hB8, 64'hFF); n++; end while (s8m != 64'h0 && n < 300);
        check("period8_model", 64'(n), 64'd255);
        s16 = 64'h0; n = 0; saw_ff = 0;
        do begin
            s16 = lfsr_step(s16, 64'hD008, 64'hFFFF);
            if (s16 == 64'hFFFF) saw_ff = 1;
            n++;
        end while (s16 != 64'h0 && n < 70000);
        check("period16_model", 64'(n), 64'd65535);
        check("period16_no_lockup", {63'b0, saw_ff}, 64'd0);

        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_valid8", {63'b0, bus8.out_valid}, 64'd0);
        check("rst_cnt8", {60'b0, cnt8}, 64'd0);
        check("rst_fix8", {63'b0, fix8}, 64'd0);
        check("rst_data8", {56'b0, bus8.out_data}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic sequence from seed 01
        sl8 = 1; seed8 = 8'h01; tick();
        sl8 = 0; en8 = 1; bus8.out_ready = 1;
        c_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_valid8(w8, c_now);
            $display("[TB] w8 word %0d = %h at cycle %0d", i, w8, c_now);
            check($sformatf("seq_word%0d", i), {56'b0, w8}, {56'b0, exp_words[i]});
            if (i > 0) check($sformatf("seq_gap%0d", i), 64'(c_now - c_prev), 64'd2);
            c_prev = c_now;
            tick();
        end
        check("seq_count4", {60'b0, cnt8}, 64'd4);

        // Backpressure
        bus8.out_ready = 0;
        wait_valid8(held8, c_now);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {63'b0, bus8.out_valid}, 64'd1);
            check("bp_data", {56'b0, bus8.out_data}, {56'b0, held8});
        end
        check("bp_count", {60'b0, cnt8}, 64'd4);
        bus8.out_ready = 1;
        tick();
        check("bp_release_count", {60'b0, cnt8}, 64'd5);

        // Lock-up seed
        sl8 = 1; seed8 = 8'hFF; tick();
        check("lockup_pulse", {63'b0, fix8}, 64'd1);
        sl8 = 0; tick();
        check("lockup_pulse_end", {63'b0, fix8}, 64'd0);
        wait_valid8(w8, c_now);
        $display("[TB] w8 after lock-up fix = %h", w8);
        check("lockup_word", {56'b0, w8}, 64'hFD);
        tick();

        // Full period of the 8-bit generator
        sl8 = 1; seed8 = 8'h00; tick();
        sl8 = 0;
        first_zero = 0; saw_ff = 0;
        for (int i = 1; i <= 255; i++) begin
            wait_valid8(w8, c_now);
            if (w8 == 8'h00 && first_zero == 0) first_zero = i;
            if (w8 == 8'hFF) saw_ff = 1;
            tick();
        end
        $display("[TB] w8 period run: first return to 00 at word %0d", first_zero);
        check("period8", 64'(first_zero), 64'd255);
        check("period8_no_ff", {63'b0, saw_ff}, 64'd0);

        // 64-bit: latency, seed load in HOLD, stretched latency, same-cycle handshake
        sl64 = 1; seed64 = {$urandom, $urandom}; tick();
        sl64 = 0; en64 = 1; n = 0;
        while (!bus64.out_valid && n < 40) begin tick(); n++; end
        $display("[TB] w64 first word %h after %0d cycles", bus64.out_data, n);
        check("lat64", 64'(n), 64'd9);
        cnt_save32 = int'(cnt64);
        sl64 = 1; seed64 = {$urandom, $urandom}; tick();
        sl64 = 0;
        check("hold_load_valid", {63'b0, bus64.out_valid}, 64'd0);
        check("hold_load_cnt", {32'b0, cnt64}, 64'(cnt_save32));
        n = 0;
        while (!bus64.out_valid && n < 60) begin
            en64 = (n == 0) ? 1'b1 : (n % 2 == 0);
            tick();
            n++;
        end
        $display("[TB] w64 stretched word %h after %0d cycles", bus64.out_data, n);
        check("lat64_stretch", 64'(n), 64'd17);
        cnt_save32 = int'(cnt64);
        sl64 = 1; bus64.out_ready = 1; tick();
        sl64 = 0; bus64.out_ready = 0;
        check("load_hs_cnt", {32'b0, cnt64}, 64'(cnt_save32 + 1));
        check("load_hs_valid", {63'b0, bus64.out_valid}, 64'd0);

        // Asynchronous reset in the middle of generation
        en64 = 1; en8 = 1; bus8.out_ready = 1;
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid8", {63'b0, bus8.out_valid}, 64'd0);
        check("arst_cnt8", {60'b0, cnt8}, 64'd0);
        check("arst_fix8", {63'b0, fix8}, 64'd0);
        check("arst_cnt64", {32'b0, cnt64}, 64'd0);
        check("arst_valid64", {63'b0, bus64.out_valid}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_valid8(w8, c_now);
        $display("[TB] w8 first word after reset = %h", w8);
        check("arst_first_word", {56'b0, w8}, 64'h01);

        // Randomised traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            sl8  = ($urandom_range(0, 30) == 0);
            seed8 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            en8  = ($urandom_range(0, 3) != 0);
            bus8.out_ready = ($urandom_range(0, 2) != 0);
            sl64 = ($urandom_range(0, 60) == 0);
            seed64 = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            en64 = ($urandom_range(0, 3) != 0);
            bus64.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        sl8 = 0; sl64 = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
